// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage driving ROM line number and holding IR for the decoder.
// FETCH_EARLY_JMP_EN: when defined, JMP opcodes (rom_data[7:6]==2'b11) redirect pc inside fetch.
module fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int unsigned LAST_ADDR = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              ir_taken,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_target,
    output logic              halted
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    typedef enum logic {HALT, FETCH} state_t;
    state_t state, state_nx;

    logic load, jmp;
    logic [ADDR_W-1:0] pc_seq, pc_nx;

`ifdef FETCH_EARLY_JMP_EN
    assign jmp = rom_data[7:6] == 2'b11;
`else
    assign jmp = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= HALT;
        else      state <= state_nx;
    end

    // Load is gated by run, so dropping run halts without consuming another ROM line.
    always_comb begin
        load     = state == FETCH && run && (!ir_valid || ir_ready) && !redir_valid;
        state_nx = state;
        if (state == HALT && run)       state_nx = FETCH;
        else if (state == FETCH && !run) state_nx = HALT;
        pc_seq = (pc == LAST) ? '0 : pc + 1'b1;
        pc_nx  = jmp ? {{(ADDR_W-6){1'b0}}, rom_data[5:0]} : pc_seq;
    end

    assign halted = state == HALT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= '0;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            ir_taken <= 1'b0;
        end else if (redir_valid) begin
            pc       <= redir_target;
            ir_valid <= 1'b0;
            ir_taken <= 1'b0;
        end else if (load) begin
            ir       <= rom_data;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            ir_taken <= jmp;
            pc       <= pc_nx;
        end else if (ir_valid && ir_ready) begin
            ir_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized checks of fetch_unit against a line-level reference model.
module tb_fetch_unit;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int LAST = 255;

    logic clk = 1'b0, rst = 1'b0, run = 1'b0, ir_ready = 1'b0, redir_valid = 1'b0;
    logic [AW-1:0] redir_target = '0;
    logic [AW-1:0] pc, ir_pc;
    logic [DW-1:0] rom_data, ir;
    logic ir_valid, ir_taken, halted;
    logic [DW-1:0] rom [256];

    logic [AW-1:0] m_pc, m_ir_pc;
    logic [DW-1:0] m_ir;
    bit m_valid, m_taken, m_fetch;
    int compared = 0, mismatched = 0;
    logic [DW-1:0] exp_ir [6];

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(LAST)) dut (
        .clk(clk), .rst(rst), .run(run), .pc(pc), .rom_data(rom_data),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .ir_taken(ir_taken), .redir_valid(redir_valid), .redir_target(redir_target),
        .halted(halted)
    );

    always #5 clk = ~clk;
    assign rom_data = rom[pc];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_ir = '0; m_ir_pc = '0; m_valid = 0; m_taken = 0; m_fetch = 0;
    endtask

    // One clock of the fetch rules, computed from the inputs applied this cycle.
    task automatic model_update();
        bit free = !m_valid || ir_ready;
        bit was_fetch = m_fetch;
        m_fetch = run;
        if (redir_valid) begin
            m_pc = redir_target; m_valid = 0; m_taken = 0;
        end else if (was_fetch && run && free) begin
            m_ir = rom[m_pc]; m_ir_pc = m_pc; m_valid = 1; m_taken = 0;
            m_pc = (m_pc == AW'(LAST)) ? '0 : m_pc + 8'd1;
`ifdef FETCH_EARLY_JMP_EN
            if (m_ir[7:6] == 2'b11) begin
                m_taken = 1;
                m_pc = {2'b00, m_ir[5:0]};
            end
`endif
        end else if (m_valid && ir_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all(string s);
        check({s, "/pc"}, 32'(pc), 32'(m_pc));
        check({s, "/ir_valid"}, 32'(ir_valid), 32'(m_valid));
        check({s, "/halted"}, 32'(halted), 32'(!m_fetch));
        check({s, "/ir"}, 32'(ir), 32'(m_ir));
        check({s, "/ir_pc"}, 32'(ir_pc), 32'(m_ir_pc));
        check({s, "/ir_taken"}, 32'(ir_taken), 32'(m_taken));
    endtask

    // Called with clk low; applies inputs, advances one rising edge, compares at the falling edge.
    task automatic step(bit r, bit rdy, bit rv, logic [AW-1:0] rt, string s);
        run = r; ir_ready = rdy; redir_valid = rv; redir_target = rt;
        model_update();
        @(posedge clk);
        @(negedge clk);
        compare_all(s);
    endtask

    initial begin
        exp_ir = '{8'h00, 8'h8B, 8'h86, 8'h19, 8'h34, 8'hC1};
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) rom[i] = exp_ir[i];
        rom[253] = 8'h12; rom[254] = 8'h34; rom[255] = 8'h00;
        model_reset();
        #1;
        check("reset/pc", 32'(pc), 0);
        check("reset/ir", 32'(ir), 0);
        check("reset/ir_pc", 32'(ir_pc), 0);
        check("reset/ir_valid", 32'(ir_valid), 0);
        check("reset/ir_taken", 32'(ir_taken), 0);
        check("reset/halted", 32'(halted), 1);
        #2 rst = 1'b1;
        @(negedge clk);

        step(1, 1, 0, 0, "start");
        check("start/no_load", 32'(ir_valid), 0);
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 0, 0, "seq");
            check("seq/ir_const", 32'(ir), 32'(exp_ir[i]));
            check("seq/ir_pc_const", 32'(ir_pc), i);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, "stall");
            check("stall/ir", 32'(ir), 32'h8B);
            check("stall/pc", 32'(pc), 2);
        end
        for (int i = 2; i < 6; i++) begin
            step(1, 1, 0, 0, "seq2");
            check("seq2/ir_const", 32'(ir), 32'(exp_ir[i]));
            check("seq2/ir_pc_const", 32'(ir_pc), i);
        end
`ifdef FETCH_EARLY_JMP_EN
        check("jmp/taken", 32'(ir_taken), 1);
        step(1, 1, 0, 0, "after_jmp");
        check("after_jmp/ir_pc", 32'(ir_pc), 1);
`else
        check("jmp/taken", 32'(ir_taken), 0);
        step(1, 1, 0, 0, "after_jmp");
        check("after_jmp/ir_pc", 32'(ir_pc), 6);
`endif
        step(1, 1, 1, 8'd1, "redir");
        check("redir/flush", 32'(ir_valid), 0);
        step(1, 1, 0, 0, "redir_load");
        check("redir_load/ir", 32'(ir), 32'h8B);
        check("redir_load/ir_pc", 32'(ir_pc), 1);

        step(1, 1, 1, 8'd253, "wrap_redir");
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, "wrap");
        check("wrap/ir_pc", 32'(ir_pc), 0);

        step(1, 1, 1, 8'd0, "halt_redir");
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, "to3");
        check("to3/ir_pc", 32'(ir_pc), 3);
        step(0, 1, 0, 0, "halt");
        check("halt/halted", 32'(halted), 1);
        check("halt/pc", 32'(pc), 4);
        step(0, 1, 0, 0, "halt_hold");
        check("halt_hold/pc", 32'(pc), 4);
        step(1, 1, 0, 0, "resume");
        step(1, 1, 0, 0, "resume_load");
        check("resume_load/ir_pc", 32'(ir_pc), 4);

        #2 rst = 1'b0;
        model_reset();
        #1;
        check("async/pc", 32'(pc), 0);
        check("async/ir_valid", 32'(ir_valid), 0);
        check("async/halted", 32'(halted), 1);
        @(negedge clk);
        compare_all("in_reset");
        rst = 1'b1;

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 7) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
                 8'($urandom), "rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
